// File: rtl/cpu_bus_pkg.sv
// Shared bus definitions: arbiter state encoding and default data width.
package cpu_bus_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // IDLE: nobody drives the bus; OWNED: exactly one source holds it.
    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant/data bundle between the bus sources and the arbiter.
interface bus_arbiter_if
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NSRC  = 27
);
    localparam int IW = $clog2(NSRC);

    logic [NSRC-1:0]       req;
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       grant;
    logic [IW-1:0]         grant_idx;
    logic                  bus_valid;
    logic [WIDTH-1:0]      bus_out;
    logic                  timeout;

    // Source side: raises requests and presents data.
    modport master (
        output req, src_data,
        input  grant, grant_idx, bus_valid, bus_out, timeout
    );

    // Arbiter side.
    modport slave (
        input  req, src_data,
        output grant, grant_idx, bus_valid, bus_out, timeout
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: first eligible index at or after ptr, wrapping at NSRC-1.
module rr_pick #(
    parameter  int NSRC = 27,
    localparam int IW   = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] elig,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    // Walk candidates ptr, ptr+1, ... modulo NSRC; keep the first hit.
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] cand;
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NSRC; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NSRC)) sum = sum - (IW+1)'(NSRC);
            cand = sum[IW-1:0];
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with hold limit, forced revoke and registered bus-keeper output.
module bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int NSRC     = 27,
    parameter int MAX_HOLD = 16
) (
    input  logic          clock,
    input  logic          clear,
    bus_arbiter_if.slave  bus
);

    localparam int IW = $clog2(NSRC);
    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t                      state_q, state_d;
    logic [IW-1:0]               ptr_q, ptr_d;
    logic [IW-1:0]               owner_q, owner_d;
    logic [HW-1:0]               hold_q, hold_d;
    logic [NSRC-1:0]             mask_q, mask_d;
    logic                        timeout_q, timeout_d;
    logic [WIDTH-1:0]            bus_out_q, bus_out_d;

    logic [NSRC-1:0]             elig;
    logic                        pick_found;
    logic [IW-1:0]               pick_idx;
    logic [NSRC-1:0][WIDTH-1:0]  src_arr;

    // A revoked source stays masked until it drops its request.
    assign elig    = bus.req & ~mask_q;
    assign src_arr = bus.src_data;

    rr_pick #(.NSRC(NSRC)) u_pick (
        .elig  (elig),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State register; clear forces everything to zero asynchronously.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            hold_q    <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
            bus_out_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
            bus_out_q <= bus_out_d;
        end
    end

    // Next state: grant from IDLE, release or revoke from OWNED; release beats expiry.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        mask_d    = mask_q & bus.req;
        timeout_d = timeout_q;
        bus_out_d = bus_out_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = OWNED;
                    owner_d = pick_idx;
                    hold_d  = HW'(1);
                end
            end
            OWNED: begin
                if (!bus.req[owner_q] || hold_q == HW'(MAX_HOLD)) begin
                    state_d = IDLE;
                    owner_d = '0;
                    hold_d  = '0;
                    ptr_d   = (owner_q == IW'(NSRC-1)) ? '0 : owner_q + 1'b1;
                    if (bus.req[owner_q]) begin
                        timeout_d        = 1'b1;
                        mask_d[owner_q]  = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Bus follows the owner one cycle late; holds its value while idle.
        if (state_d == OWNED) bus_out_d = src_arr[owner_d];
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.grant     = '0;
        bus.bus_valid = (state_q == OWNED);
        if (state_q == OWNED) bus.grant[owner_q] = 1'b1;
        bus.grant_idx = owner_q;
        bus.bus_out   = bus_out_q;
        bus.timeout   = timeout_q;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_bus_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int MH = 4;

    logic clock = 1'b0;
    logic clear;

    bus_arbiter_if #(.WIDTH(W), .NSRC(N)) bif ();

    bus_arbiter #(.WIDTH(W), .NSRC(N), .MAX_HOLD(MH)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bif)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Model: owner -1 means idle.
    int         m_owner, m_ptr, m_hold;
    bit         m_mask [N];
    bit         m_to;
    logic [W-1:0] m_bus;
    logic [W-1:0] data [N];

    int         order[$];
    int         exp_rr[5] = '{0, 1, 2, 3, 0};
    int         valid_cnt, idle_run;
    bit         prev_valid;
    logic [N-1:0] r, f;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++) bif.src_data[i*W +: W] = data[i];
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        for (int i = 0; i < N; i++) m_mask[i] = 1'b0;
        m_to    = 1'b0;
        m_bus   = '0;
    endtask

    // One clock edge of the arbitration rules, using the inputs present before the edge.
    task automatic model_step();
        int o, c;
        bit rq [N];
        for (int i = 0; i < N; i++) rq[i] = bif.req[i];
        if (m_owner < 0) begin
            o = -1;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (o < 0 && rq[c] && !m_mask[c]) o = c;
            end
            for (int i = 0; i < N; i++) if (!rq[i]) m_mask[i] = 1'b0;
            if (o >= 0) begin
                m_owner = o;
                m_hold  = 1;
                m_bus   = data[o];
            end
        end else begin
            o = m_owner;
            for (int i = 0; i < N; i++) if (!rq[i]) m_mask[i] = 1'b0;
            if (!rq[o]) begin
                m_owner = -1;
                m_ptr   = (o + 1) % N;
            end else if (m_hold == MH) begin
                m_owner   = -1;
                m_ptr     = (o + 1) % N;
                m_to      = 1'b1;
                m_mask[o] = 1'b1;
            end else begin
                m_hold++;
                m_bus = data[o];
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check({tag, ".grant"},     W'(bif.grant),     eg);
        check({tag, ".grant_idx"}, W'(bif.grant_idx), (m_owner < 0) ? '0 : W'(m_owner));
        check({tag, ".bus_valid"}, W'(bif.bus_valid), W'(m_owner >= 0));
        check({tag, ".bus_out"},   bif.bus_out,       m_bus);
        check({tag, ".timeout"},   W'(bif.timeout),   W'(m_to));
    endtask

    task automatic tick(input string tag);
        drive_data();
        model_step();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset state
        clear   = 1'b1;
        bif.req = '0;
        for (int i = 0; i < N; i++) data[i] = '0;
        drive_data();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        clear = 1'b0;

        // Round-robin order, each owner keeps the bus two cycles
        prev_valid = 1'b0;
        idle_run   = 0;
        for (int i = 0; i < N; i++) data[i] = 32'hA000_0000 + i;
        for (int cyc = 0; cyc < 40 && order.size() < 5; cyc++) begin
            r = '1;
            if (m_owner >= 0 && m_hold == 2) r[m_owner] = 1'b0;
            bif.req = r;
            tick("rr");
            if (bif.bus_valid && !prev_valid) begin
                if (order.size() > 0) check("rr_idle_gap", W'(idle_run), 1);
                order.push_back(int'(bif.grant_idx));
            end
            idle_run   = bif.bus_valid ? 0 : idle_run + 1;
            prev_valid = bif.bus_valid;
        end
        check("rr_count", W'(order.size()), 5);
        for (int i = 0; i < order.size() && i < 5; i++) check("rr_order", W'(order[i]), W'(exp_rr[i]));
        bif.req = '0;
        tick("rr_end");

        // Wrap-around: source 3 releases so the search restarts at 0
        bif.req = 4'b1000;
        tick("wrap_g3");
        check("wrap_owner3", W'(bif.grant_idx), 3);
        bif.req = '0;
        tick("wrap_rel");
        bif.req = 4'b1010;
        tick("wrap_pick");
        check("wrap_idx", W'(bif.grant_idx), 1);
        bif.req = '0;
        tick("wrap_end");

        // Release on the last allowed hold cycle is a plain release
        data[1] = 32'h1111_0001;
        bif.req = 4'b0010;
        tick("coin_grant");
        check("coin_idx", W'(bif.grant_idx), 1);
        repeat (3) tick("coin_hold");
        bif.req = '0;
        tick("coin_release");
        check("coin_timeout", W'(bif.timeout), 0);
        bif.req = 4'b0010;
        tick("coin_regrant");
        check("coin_not_masked", W'(bif.bus_valid), 1);
        bif.req = '0;
        tick("coin_end");

        // Forced revoke after MAX_HOLD cycles, then masked until req drops
        data[1]   = 32'hDEAD_BEEF;
        bif.req   = 4'b0010;
        valid_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick("rv");
            if (bif.bus_valid) begin
                valid_cnt++;
                check("rv_bus", bif.bus_out, 32'hDEAD_BEEF);
            end
        end
        check("rv_cycles", W'(valid_cnt), 4);
        check("rv_timeout", W'(bif.timeout), 1);
        check("rv_grant", W'(bif.grant), 0);
        bif.req = '0;
        tick("rv_drop");
        bif.req = 4'b0010;
        tick("rv_regrant");
        check("rv_regrant_idx", W'(bif.grant_idx), 1);
        check("rv_regrant_valid", W'(bif.bus_valid), 1);
        bif.req = '0;
        tick("rv_end");

        // Bus keeper: value stays after release while data changes
        data[0] = 32'h0000_1234;
        bif.req = 4'b0001;
        tick("bk_grant");
        bif.req = '0;
        data[0] = 32'hFFFF_0000;
        tick("bk_rel");
        repeat (3) begin
            tick("bk_idle");
            check("bk_bus", bif.bus_out, 32'h0000_1234);
            check("bk_valid", W'(bif.bus_valid), 0);
        end

        // Asynchronous clear while source 2 owns
        data[2] = 32'h2222_2222;
        bif.req = 4'b0100;
        tick("mr_grant");
        tick("mr_hold");
        #2;
        clear = 1'b1;
        #1;
        check("mr_grant0", W'(bif.grant), 0);
        check("mr_idx0", W'(bif.grant_idx), 0);
        check("mr_valid0", W'(bif.bus_valid), 0);
        check("mr_bus0", bif.bus_out, 0);
        check("mr_timeout0", W'(bif.timeout), 0);
        model_reset();
        @(posedge clock);
        #1;
        clear = 1'b0;
        tick("mr_regrant");
        check("mr_regrant_idx", W'(bif.grant_idx), 2);

        // Random traffic: requests toggle with probability 1/4 per bit
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                f[i]    = ($urandom_range(3) == 0);
                data[i] = $urandom;
            end
            bif.req = bif.req ^ f;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
